bridge_arbiter: RTL
===================

# bridge_arbiter

Two-requester arbiter in front of the system's 16-bit external bus-to-Avalon memory bridge (`bridge_memory_*`).
- It lets the game-logic engine (m0) and the sprite/framebuffer drawer (m1) share the one bridge port.
- Arbitration is round-robin; one transaction is in flight at a time.
- An optional watchdog times out stalled transactions.

## Interface
Parameters:
- `ADDR_W`, 27: bridge address width.
- `DATA_W`, 16: bridge data width; byte enables are `DATA_W/8`.
- `TIMEOUT`, 255: cycles without acknowledge before abort (timeout build only); range 1..65535.

Ports. `mN_*` is replicated for N=0,1.
- `clk_clk` input 1: single clock. Everything is synchronous to its rising edge.
- `reset_reset` input 1: synchronous, active-high reset.
- `mN_address` input ADDR_W: requester address.
- `mN_byte_enable` input DATA_W/8: requester byte enables.
- `mN_read` input 1: read request, held until acknowledged.
- `mN_write` input 1: write request, held until acknowledged.
- `mN_write_data` input DATA_W: write data.
- `mN_acknowledge` output 1: one-cycle completion pulse.
- `mN_read_data` output DATA_W: read data, valid while `mN_acknowledge`=1.
- `bridge_memory_address` output ADDR_W: to bridge.
- `bridge_memory_byte_enable` output DATA_W/8: to bridge.
- `bridge_memory_read` output 1: to bridge.
- `bridge_memory_write` output 1: to bridge.
- `bridge_memory_write_data` output DATA_W: to bridge.
- `bridge_memory_acknowledge` input 1: from bridge.
- `bridge_memory_read_data` input DATA_W: from bridge.
- `busy` output 1: high in BUSY and ACK.
- `err` output 1: sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - Requester N is requesting when `mN_read|mN_write`.
  - If exactly one requests, grant it.
  - If both request, grant the one not in `last_grant`, then set `last_grant` to the winner.
  - On grant, latch the winner's address, byte_enable, write_data and op.
  - Write wins if read and write are both high. This is illegal, and the read is dropped.
  - Go to BUSY.
- BUSY:
  - Bridge outputs are driven from the latched registers.
  - Exactly one of `bridge_memory_read`/`bridge_memory_write` is high.
  - On an edge with `bridge_memory_acknowledge`=1:
    - capture `bridge_memory_read_data` (reads; zero for writes)
    - deassert bridge read/write
    - go to ACK
- ACK:
  - For exactly one cycle, `mN_acknowledge`=1 for the granted N only, and `mN_read_data` holds the captured data.
  - Then go to IDLE.
  - Requesters clear read/write on the edge that ends ACK, so IDLE never re-grants a completed request.
- Non-granted requesters wait with their requests held; nothing of theirs is latched.
- Requests changing while BUSY have no effect; the latched command is used.
- Bridge acknowledge outside BUSY is ignored.
- Reset:
  - All outputs are 0, state is IDLE, `last_grant`=1 (m0 wins the first tie), `err`=0.
  - Reset mid-transaction drops the command at the next edge; no acknowledge is issued.

## Timing
- Request first seen high at IDLE cycle 0 → bridge command is valid in cycle 1.
- Bridge acknowledge in cycle k → `mN_acknowledge` in cycle k+1 → IDLE in cycle k+2.
- Minimum transaction, with acknowledge in cycle 1: 3 cycles from request to the next possible grant.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `mN_read_data` outside ACK is 0.

## Configuration
- `BRIDGE_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without acknowledge.
  - When it reaches TIMEOUT, bridge read/write deassert, captured data = 0, and the FSM goes to ACK, so the requester gets a normal acknowledge.
  - `err` sets and stays set until reset.
  - An acknowledge on the same edge as expiry wins: normal completion, no error.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - `err` is tied 0.

## Test plan
- After reset, m0 write addr 0x0000123, be 2'b11, data 0xBEEF; bridge acks in cycle 3 → bridge_memory_write high cycles 1–3 with those values; m0_acknowledge pulses in cycle 4; m1_acknowledge stays 0.
- m0 and m1 both read at cycle 0 with continuous requests; bridge returns 0x1111 then 0x2222 → m0 served first, then m1, alternating strictly; read data lands on the correct requester.
- m1 read in progress while reset_reset pulses in cycle 2 → all outputs 0 at cycle 3; no acknowledge to m1; the next request is served normally.
- m0 holds read and write together, data 0x00FF → only bridge_memory_write asserted.
- With `BRIDGE_ARB_TIMEOUT_EN` and TIMEOUT=4, bridge never acks → bridge_memory_read drops after 4 BUSY cycles; m0_acknowledge pulses with read_data 0x0000; err=1 and stays 1.
- With `BRIDGE_ARB_TIMEOUT_EN` and TIMEOUT=4, acknowledge lands on the expiry edge → normal completion with the bridge's read data; err stays 0.

Source files
------------

// File: rtl/bridge_arbiter.sv
// bridge_arbiter
//   Two-requester round-robin arbiter in front of the 16-bit external
//   bus-to-Avalon memory bridge. m0 is the game-logic engine, m1 the
//   sprite/framebuffer drawer. One transaction is in flight at a time.
//
//   Build option: define BRIDGE_ARB_TIMEOUT_EN to add a watchdog that aborts
//   a transaction after TIMEOUT busy cycles without a bridge acknowledge.
//   The abort completes with zero read data and sets the sticky err flag.
//
// Ports
//   clk_clk, reset_reset        : clock, synchronous active-high reset
//   mN_address/byte_enable/read/write/write_data : requester N command (held
//                                 until acknowledged)
//   mN_acknowledge, mN_read_data: one-cycle completion pulse and read data
//   bridge_memory_*             : command to / response from the bridge
//   busy                        : transaction in progress (BUSY or ACK)
//   err                         : sticky watchdog timeout flag
module bridge_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byte_enable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_write_data,
  output logic                m0_acknowledge,
  output logic [DATA_W-1:0]   m0_read_data,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byte_enable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_write_data,
  output logic                m1_acknowledge,
  output logic [DATA_W-1:0]   m1_read_data,
  output logic [ADDR_W-1:0]   bridge_memory_address,
  output logic [DATA_W/8-1:0] bridge_memory_byte_enable,
  output logic                bridge_memory_read,
  output logic                bridge_memory_write,
  output logic [DATA_W-1:0]   bridge_memory_write_data,
  input  logic                bridge_memory_acknowledge,
  input  logic [DATA_W-1:0]   bridge_memory_read_data,
  output logic                busy,
  output logic                err
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   gnt, gnt_nxt;
  logic   latch_en, cap_en;
  logic   expire;
  logic   req0, req1, win;

  logic [ADDR_W-1:0] cmd_addr;
  logic [BE_W-1:0]   cmd_be;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_wr;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  // On a tie the requester not granted last time wins; otherwise the lone one.
  assign win  = (req0 & req1) ? ~last_grant : ~req0;

`ifdef BRIDGE_ARB_TIMEOUT_EN
  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] cnt;
  logic        err_q;

  // Counter sits at zero in IDLE, so it is cleared on entry to BUSY.
  always_ff @(posedge clk_clk) begin
    if (reset_reset || state != BUSY) cnt <= '0;
    else                              cnt <= cnt + 16'd1;
  end

  // A bridge acknowledge on the expiry edge takes priority over the abort.
  assign expire = (state == BUSY) && !bridge_memory_acknowledge && (cnt == CNT_LIMIT);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) err_q <= 1'b0;
    else if (expire) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign expire         = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      gnt        <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    last_grant_nxt = last_grant;
    latch_en       = 1'b0;
    cap_en         = 1'b0;
    rdata_nxt      = '0;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          state_nxt = BUSY;
          gnt_nxt   = win;
          latch_en  = 1'b1;
          if (req0 & req1) last_grant_nxt = win;
        end
      end
      BUSY: begin
        if (bridge_memory_acknowledge) begin
          state_nxt = ACK;
          cap_en    = 1'b1;
          rdata_nxt = cmd_wr ? '0 : bridge_memory_read_data;
        end else if (expire) begin
          state_nxt = ACK;
          cap_en    = 1'b1;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command and response holding registers; every output use is qualified by
  // state, so they need no reset.
  always_ff @(posedge clk_clk) begin
    if (latch_en) begin
      cmd_addr  <= win ? m1_address     : m0_address;
      cmd_be    <= win ? m1_byte_enable : m0_byte_enable;
      cmd_wdata <= win ? m1_write_data  : m0_write_data;
      // Read and write together is illegal; the write is kept.
      cmd_wr    <= win ? m1_write       : m0_write;
    end
    if (cap_en) rdata_q <= rdata_nxt;
  end

  assign busy                      = (state != IDLE);
  assign bridge_memory_read        = (state == BUSY) && !cmd_wr;
  assign bridge_memory_write       = (state == BUSY) && cmd_wr;
  assign bridge_memory_address     = (state == BUSY) ? cmd_addr  : '0;
  assign bridge_memory_byte_enable = (state == BUSY) ? cmd_be    : '0;
  assign bridge_memory_write_data  = (state == BUSY) ? cmd_wdata : '0;
  assign m0_acknowledge            = (state == ACK) && !gnt;
  assign m1_acknowledge            = (state == ACK) && gnt;
  assign m0_read_data              = m0_acknowledge ? rdata_q : '0;
  assign m1_read_data              = m1_acknowledge ? rdata_q : '0;

endmodule
